// File: rtl/kit_voice_mixer_scheduler.sv
// Mixer/scheduler that time-shares the codec write port among NUM_VOICES voices:
// per frame it collects one sample from every masked voice in index order and writes the saturated sum.
module kit_voice_mixer_scheduler #(
    parameter int NUM_VOICES = 6,
    parameter int SAMPLE_W   = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES-1:0]          voice_req,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]          voice_grant,
    input  logic                           audio_out_allowed,
    output logic                           write_audio_out,
    output logic [SAMPLE_W-1:0]            audio_out,
    output logic                           clear_buffer,
    output logic                           underrun
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_wait_cnt;
    logic [NUM_VOICES-1:0]    r_frame_mask;
    logic [SAMPLE_W-1:0]      r_audio_out;
    logic                     r_clear;
    logic                     r_underrun;
    logic                     r_any_active;

    logic [SAMPLE_W-1:0]      w_sample;
    logic signed [ACC_W-1:0]  w_sample_ext;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic                     w_mask_bit;
    logic                     w_take;
    logic                     w_timeout;
    logic                     w_last;
    logic [NUM_VOICES-1:0]    w_grant;

    // Clamp the wide accumulator into the signed output range.
    function automatic logic [SAMPLE_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [SAMPLE_W-1:0] res;
        if (v > SAT_MAX) begin
            res = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            res = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            res = v[SAMPLE_W-1:0];
        end
        return res;
    endfunction

    // Select the current voice's sample with an AND-OR mux over the packed bus.
    always_comb begin
        w_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sample = w_sample |
                       ({SAMPLE_W{r_idx == IDX_W'(i)}} & voice_sample[i*SAMPLE_W +: SAMPLE_W]);
        end
    end

    assign w_sample_ext = {{(ACC_W-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};
    assign w_acc_sum    = r_acc + w_sample_ext;
    assign w_mask_bit   = r_frame_mask[r_idx];
    assign w_take       = (r_state == S_COLLECT) & w_mask_bit & voice_req[r_idx];
    // A request arriving on the timeout cycle wins, so timeout requires no request.
    assign w_timeout    = (r_state == S_COLLECT) & w_mask_bit & ~voice_req[r_idx] &
                          (r_wait_cnt == WAIT_LIMIT);
    assign w_last       = (r_idx == LAST_IDX);

    // One-hot grant to the voice being collected; suppressed while reset is held.
    always_comb begin
        w_grant = '0;
        if (!reset && w_take) begin
            w_grant[r_idx] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    assign voice_grant     = w_grant;
    assign write_audio_out = (r_state == S_WRITE) & audio_out_allowed & ~reset;
    assign audio_out       = r_audio_out;
    assign clear_buffer    = r_clear;
    assign underrun        = r_underrun;

    // Frame FSM, accumulator, and the registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_acc        <= '0;
            r_wait_cnt   <= '0;
            r_frame_mask <= '0;
            r_audio_out  <= '0;
            r_clear      <= 1'b0;
            r_underrun   <= 1'b0;
            r_any_active <= 1'b0;
        end else begin
            r_any_active <= |voice_active;
            r_clear      <= r_any_active & ~(|voice_active);
            r_underrun   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|voice_active) begin
                        r_frame_mask <= voice_active;
                        r_idx        <= '0;
                        r_acc        <= '0;
                        r_wait_cnt   <= '0;
                        r_state      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (!w_mask_bit || w_take || w_timeout) begin
                        r_wait_cnt <= '0;
                        if (w_take) begin
                            r_acc <= w_acc_sum;
                        end
                        if (w_timeout) begin
                            r_underrun <= 1'b1;
                        end
                        if (w_last) begin
                            r_audio_out <= sat_fn(w_take ? w_acc_sum : r_acc);
                            r_state     <= S_WRITE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (audio_out_allowed) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kit_voice_mixer_scheduler.sv
// Directed bench for kit_voice_mixer_scheduler (6 voices, 10-bit samples, TIMEOUT=4).
module tb_kit_voice_mixer_scheduler;

    logic        clock;
    logic        reset;
    logic [5:0]  voice_active;
    logic [5:0]  voice_req;
    logic [59:0] voice_sample;
    logic [5:0]  voice_grant;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [9:0]  audio_out;
    logic        clear_buffer;
    logic        underrun;

    logic signed [9:0] smp [6];

    int n_vec;
    int n_err;

    // observation results from the most recent run_window
    int         o_wr, o_wr_k, o_last_k, o_un, o_cl, o_gr, o_bad, o_chg;
    logic [9:0] o_wr_val;
    logic [5:0] o_gr_or;

    kit_voice_mixer_scheduler #(
        .NUM_VOICES(6),
        .SAMPLE_W  (10),
        .TIMEOUT   (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .voice_active     (voice_active),
        .voice_req        (voice_req),
        .voice_sample     (voice_sample),
        .voice_grant      (voice_grant),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out  (write_audio_out),
        .audio_out        (audio_out),
        .clear_buffer     (clear_buffer),
        .underrun         (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < 6; i++) voice_sample[i*10 +: 10] = smp[i];
    end

    // Runs n cycles from just after a rising edge (cycle 1 = current one), applying
    // scheduled input changes at the start of a cycle and sampling on the falling edge.
    task automatic run_window(input int n, input int drop_k, input logic [5:0] drop_req,
                              input int raise_k, input int allow_k);
        logic [9:0] prev;
        o_wr = 0; o_wr_k = 0; o_last_k = 0; o_un = 0; o_cl = 0; o_gr = 0; o_bad = 0; o_chg = 0;
        o_wr_val = 10'd0; o_gr_or = 6'd0;
        prev = audio_out;
        for (int k = 1; k <= n; k++) begin
            if (k == drop_k) begin voice_active = 6'd0; voice_req = drop_req; end
            if (k == raise_k) voice_req = 6'b111111;
            if (k == allow_k) audio_out_allowed = 1'b1;
            @(negedge clock);
            if (write_audio_out) begin
                o_wr++;
                if (o_wr_k == 0) begin o_wr_k = k; o_wr_val = audio_out; end
                o_last_k = k;
            end
            if (underrun) o_un++;
            if (clear_buffer) o_cl++;
            if (voice_grant != 6'd0) begin
                o_gr++;
                o_gr_or = o_gr_or | voice_grant;
                if ($countones(voice_grant) != 1 || (voice_grant & ~voice_req) != 6'd0) o_bad++;
            end
            if (audio_out !== prev) o_chg++;
            prev = audio_out;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; voice_active = 6'd0; voice_req = 6'd0; audio_out_allowed = 1'b0;
        for (int i = 0; i < 6; i++) smp[i] = 10'sd0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        n_vec++; if (voice_grant !== 6'd0) begin n_err++; $display("FAIL reset_grant got %b want 000000", voice_grant); end
        n_vec++; if (write_audio_out !== 1'b0) begin n_err++; $display("FAIL reset_write got %b want 0", write_audio_out); end
        n_vec++; if (audio_out !== 10'd0) begin n_err++; $display("FAIL reset_audio got %0d want 0", audio_out); end
        n_vec++; if (clear_buffer !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL reset_pulses got clr=%b und=%b want 0 0", clear_buffer, underrun); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_voice();
        smp[0] = 10'sd100; voice_active = 6'b000001; voice_req = 6'b111111; audio_out_allowed = 1'b1;
        run_window(12, 2, 6'b111111, 0, 0);
        n_vec++; if (o_wr !== 1) begin n_err++; $display("FAIL single_writes got %0d want 1", o_wr); end
        n_vec++; if (o_wr_k !== 8) begin n_err++; $display("FAIL single_latency got cycle %0d want 8", o_wr_k); end
        n_vec++; if (o_wr_val !== 10'd100) begin n_err++; $display("FAIL single_audio got %0d want 100", o_wr_val); end
        n_vec++; if (o_gr !== 1 || o_gr_or !== 6'b000001) begin n_err++; $display("FAIL single_grant got n=%0d or=%b want 1 000001", o_gr, o_gr_or); end
        n_vec++; if (o_cl !== 1 || o_un !== 0) begin n_err++; $display("FAIL single_pulses got clr=%0d und=%0d want 1 0", o_cl, o_un); end
    endtask

    task automatic test_saturation();
        smp[0] = 10'sd300; smp[1] = 10'sd200; smp[2] = 10'sd50;
        voice_active = 6'b000111; voice_req = 6'b111111;
        run_window(12, 2, 6'b111111, 0, 0);
        n_vec++; if (o_wr_val !== 10'h1FF || o_wr !== 1) begin n_err++; $display("FAIL sat_high got %0d (writes %0d) want 511 (1)", $signed(o_wr_val), o_wr); end
        n_vec++; if (o_gr !== 3 || o_gr_or !== 6'b000111) begin n_err++; $display("FAIL sat_high_grant got n=%0d or=%b want 3 000111", o_gr, o_gr_or); end
        smp[0] = -10'sd300; smp[1] = -10'sd300; smp[2] = 10'sd10;
        voice_active = 6'b000111; voice_req = 6'b111111;
        run_window(12, 2, 6'b111111, 0, 0);
        n_vec++; if (o_wr_val !== 10'h200 || o_wr !== 1) begin n_err++; $display("FAIL sat_low got %0d (writes %0d) want -512 (1)", $signed(o_wr_val), o_wr); end
        n_vec++; if (o_bad !== 0) begin n_err++; $display("FAIL sat_low_onehot got %0d bad grants want 0", o_bad); end
    endtask

    task automatic test_sum_all();
        smp[0] = 10'sd100; smp[1] = -10'sd50; smp[2] = 10'sd20;
        smp[3] = 10'sd30;  smp[4] = -10'sd10; smp[5] = 10'sd5;
        voice_active = 6'b111111; voice_req = 6'b111111;
        run_window(12, 2, 6'b111111, 0, 0);
        n_vec++; if (o_wr_val !== 10'd95) begin n_err++; $display("FAIL sum_all got %0d want 95", $signed(o_wr_val)); end
        n_vec++; if (o_gr !== 6 || o_gr_or !== 6'b111111 || o_bad !== 0) begin n_err++; $display("FAIL sum_all_grant got n=%0d or=%b bad=%0d want 6 111111 0", o_gr, o_gr_or, o_bad); end
        n_vec++; if (o_wr_k !== 8) begin n_err++; $display("FAIL sum_all_latency got %0d want 8", o_wr_k); end
    endtask

    task automatic test_timeout();
        smp[0] = 10'sd7; smp[1] = 10'sd3;
        voice_active = 6'b000011; voice_req = 6'b000001;
        run_window(16, 2, 6'b000001, 0, 0);
        n_vec++; if (o_un !== 1) begin n_err++; $display("FAIL timeout_underrun got %0d want 1", o_un); end
        n_vec++; if (o_wr !== 1 || o_wr_val !== 10'd7) begin n_err++; $display("FAIL timeout_write got n=%0d val=%0d want 1 7", o_wr, o_wr_val); end
        n_vec++; if (o_wr_k !== 11) begin n_err++; $display("FAIL timeout_latency got %0d want 11", o_wr_k); end
        n_vec++; if (o_gr_or !== 6'b000001) begin n_err++; $display("FAIL timeout_grant got %b want 000001", o_gr_or); end
    endtask

    task automatic test_request_wins();
        voice_active = 6'b000011; voice_req = 6'b000001;
        run_window(16, 2, 6'b000001, 6, 0);
        n_vec++; if (o_un !== 0) begin n_err++; $display("FAIL reqwins_underrun got %0d want 0", o_un); end
        n_vec++; if (o_wr_val !== 10'd10 || o_wr !== 1) begin n_err++; $display("FAIL reqwins_audio got %0d (writes %0d) want 10 (1)", o_wr_val, o_wr); end
        n_vec++; if (o_gr !== 2 || o_gr_or !== 6'b000011) begin n_err++; $display("FAIL reqwins_grant got n=%0d or=%b want 2 000011", o_gr, o_gr_or); end
    endtask

    task automatic test_back_to_back();
        smp[0] = -10'sd5;
        voice_active = 6'b000001; voice_req = 6'b111111; audio_out_allowed = 1'b0;
        run_window(40, 31, 6'b111111, 0, 28);
        n_vec++; if (o_wr_k !== 28) begin n_err++; $display("FAIL backpressure_first got %0d want 28", o_wr_k); end
        n_vec++; if (o_wr_val !== 10'h3FB) begin n_err++; $display("FAIL backpressure_audio got %0d want -5", $signed(o_wr_val)); end
        n_vec++; if (o_chg !== 1) begin n_err++; $display("FAIL backpressure_hold got %0d changes want 1", o_chg); end
        n_vec++; if (o_wr !== 2 || o_last_k !== 36) begin n_err++; $display("FAIL back_to_back got n=%0d last=%0d want 2 36", o_wr, o_last_k); end
        n_vec++; if (o_gr !== 2) begin n_err++; $display("FAIL back_to_back_grant got %0d want 2", o_gr); end
    endtask

    task automatic test_clear_mask();
        smp[0] = 10'sd40; smp[1] = 10'sd2;
        voice_active = 6'b000011; voice_req = 6'b111111;
        run_window(20, 3, 6'b000001, 0, 0);
        n_vec++; if (o_cl !== 1) begin n_err++; $display("FAIL clear_pulse got %0d want 1", o_cl); end
        n_vec++; if (o_wr !== 1 || o_wr_val !== 10'd40) begin n_err++; $display("FAIL clear_frame got n=%0d val=%0d want 1 40", o_wr, o_wr_val); end
        n_vec++; if (o_un !== 1 || o_wr_k !== 11) begin n_err++; $display("FAIL clear_timeout got und=%0d k=%0d want 1 11", o_un, o_wr_k); end
    endtask

    task automatic test_reset_mid_frame();
        smp[0] = 10'sd100; smp[1] = 10'sd50;
        voice_active = 6'b000011; voice_req = 6'b111111; audio_out_allowed = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        n_vec++; if (voice_grant !== 6'b000001) begin n_err++; $display("FAIL rstmid_pre_grant got %b want 000001", voice_grant); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (voice_grant !== 6'd0 || write_audio_out !== 1'b0) begin n_err++; $display("FAIL rstmid_drop got g=%b w=%b want 000000 0", voice_grant, write_audio_out); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_vec++; if (voice_grant !== 6'd0 || write_audio_out !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got g=%b w=%b u=%b want 000000 0 0", voice_grant, write_audio_out, underrun); end
        n_vec++; if (audio_out !== 10'd0) begin n_err++; $display("FAIL rstmid_audio got %0d want 0", audio_out); end
        @(posedge clock); #1;
        run_window(12, 2, 6'b111111, 0, 0);
        n_vec++; if (o_wr_val !== 10'd150 || o_wr !== 1) begin n_err++; $display("FAIL rstmid_sum got %0d (writes %0d) want 150 (1)", o_wr_val, o_wr); end
        n_vec++; if (o_wr_k !== 7) begin n_err++; $display("FAIL rstmid_latency got %0d want 7", o_wr_k); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_voice();
        test_saturation();
        test_sum_all();
        test_timeout();
        test_request_wins();
        test_back_to_back();
        test_clear_mask();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
